// File: rtl/rf_write_arbiter_if.sv
// Request and write-port bundle for rf_write_arbiter.
// Handshake: requester i holds req_valid[i] with stable req_addr/req_data until a cycle
// where req_valid[i] & req_ready[i]; that cycle is the transfer. req_ready never waits on itself.
interface rf_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      regwrite;
    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, regwrite, write_reg, write_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, regwrite, write_reg, write_data
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the register-file write port, with a post-reset clearing sweep of x1..xN.
// Optional stall counter output enabled by defining RFARB_STALL_CNT_EN.
module rf_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int INIT_SWEEP = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    rf_write_arbiter_if.slave    bus,
`ifdef RFARB_STALL_CNT_EN
    output logic [31:0]          stall_count,
`endif
    output logic                 init_done,
    output logic                 dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RST_STATE = (INIT_SWEEP != 0) ? ST_INIT : ST_RUN;
    localparam logic   RST_DONE  = (INIT_SWEEP == 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic                regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                init_done_q, init_done_d;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_data;
    logic [NUM_REQ-1:0]  ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RST_STATE;
            cnt_q        <= ADDR_W'(1);
            rr_q         <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            init_done_q  <= RST_DONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            init_done_q  <= init_done_d;
        end
    end

    // Next-state logic: the write port is always registered one cycle after its source.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        init_done_d  = init_done_q;
        case (state_q)
            ST_INIT: begin
                regwrite_d   = 1'b1;
                write_reg_d  = cnt_q;
                write_data_d = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (grant_vld) begin
                    rr_d         = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    regwrite_d   = (grant_addr != '0);
                    write_reg_d  = grant_addr;
                    write_data_d = grant_data;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Output logic: grant scan starts at rr_q and wraps; no grant while resetting or sweeping.
    always_comb begin
        int idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        ready      = '0;
        if (!reset && state_q == ST_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = PTR_W'(idx);
                    grant_addr = bus.req_addr[idx*ADDR_W +: ADDR_W];
                    grant_data = bus.req_data[idx*DATA_W +: DATA_W];
                    ready[idx] = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.regwrite   = regwrite_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign init_done      = init_done_q;
    assign dbg_state      = (state_q == ST_RUN);

`ifdef RFARB_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_RUN && |(bus.req_valid & ~ready) && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter against a queue-based reference model.
// Define RFARB_STALL_CNT_EN to also check stall_count.
module tb_rf_write_arbiter;
    localparam int N    = 2;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int W    = 32 + 1 + 1 + AW + DW;
    localparam logic [DW-1:0] SENTINEL = 64'hA5A5_A5A5_A5A5_A5A5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    logic dbg_state;
`ifdef RFARB_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    rf_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_write_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .INIT_SWEEP(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
`ifdef RFARB_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .init_done   (init_done),
        .dbg_state   (dbg_state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    // Stimulus state (what each requester presents next cycle)
    logic           nrst = 1'b1;
    logic [N-1:0]   nv = '0;
    logic [AW-1:0]  na[N];
    logic [DW-1:0]  nd[N];
    logic [N-1:0]   acc = '0;

    // Reference model state
    bit             m_init = 1'b1;
    int             m_idx = 1;
    int             m_ptr = 0;
    logic           m_rw = 1'b0;
    logic [AW-1:0]  m_reg = '0;
    logic [DW-1:0]  m_data = '0;
    logic           m_done = 1'b0;
    logic [31:0]    m_stall = '0;
    logic [DW-1:0]  rf_model[NREG];
    logic [DW-1:0]  rf_dut[NREG];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one call per cycle, after inputs settle.
    task automatic model_step();
        int g;
        int idx;
        int waiting;
        logic [N-1:0] exp_rdy;
        g = -1;
        exp_rdy = '0;
        waiting = 0;
        if (!nrst && !m_init) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && nv[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", DW'(bus.req_ready), DW'(exp_rdy));
        acc = exp_rdy;
        if (nrst) begin
            m_init = 1'b1; m_idx = 1; m_ptr = 0;
            m_rw = 1'b0; m_reg = '0; m_data = '0; m_done = 1'b0; m_stall = '0;
        end else if (m_init) begin
            m_rw = 1'b1; m_reg = AW'(m_idx); m_data = '0;
            rf_model[m_idx] = '0;
            if (m_idx == NREG - 1) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
            m_idx++;
        end else begin
            for (int i = 0; i < N; i++)
                if (nv[i] && i != g) waiting++;
            if (waiting > 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (g >= 0) begin
                m_ptr  = (g + 1) % N;
                m_reg  = na[g];
                m_data = nd[g];
                m_rw   = (na[g] != '0);
                if (m_rw) rf_model[na[g]] = nd[g];
            end else begin
                m_rw = 1'b0;
            end
        end
        exp_q.push_back({m_stall, m_done, m_rw, m_reg, m_data});
    endtask

    // Driver: apply inputs just after the edge, run the model before the next one.
    task automatic step();
        @(posedge clock);
        #1;
        reset = nrst;
        bus.req_valid = nv;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = na[i];
            bus.req_data[i*DW +: DW] = nd[i];
        end
        #2;
        model_step();
    endtask

    task automatic rand_cycles(input int n, input int rst_per_mille);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!nv[i] || acc[i]) begin
                    nv[i] = ($urandom_range(0, 99) < 55);
                    na[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
                    nd[i] = {$urandom, $urandom};
                end
            end
            nrst = ($urandom_range(0, 999) < rst_per_mille);
            step();
        end
        nrst = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0]  e;
        logic [31:0]   e_stall;
        logic          e_done;
        logic          e_rw;
        logic [AW-1:0] e_reg;
        logic [DW-1:0] e_data;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                {e_stall, e_done, e_rw, e_reg, e_data} = e;
                chk("regwrite",   DW'(bus.regwrite),  DW'(e_rw));
                chk("init_done",  DW'(init_done),     DW'(e_done));
                chk("write_reg",  DW'(bus.write_reg), DW'(e_reg));
                chk("write_data", bus.write_data,     e_data);
`ifdef RFARB_STALL_CNT_EN
                chk("stall_count", DW'(stall_count), DW'(e_stall));
`endif
                if (bus.regwrite === 1'b1) rf_dut[bus.write_reg] = bus.write_data;
            end
        end
    end

    // Test sequence
    initial begin
        for (int r = 0; r < NREG; r++) begin
            rf_model[r] = SENTINEL;
            rf_dut[r]   = SENTINEL;
        end
        for (int i = 0; i < N; i++) begin
            na[i] = '0;
            nd[i] = '0;
        end
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        nrst = 1'b1;
        repeat (3) step();
        nrst = 1'b0;
        repeat (NREG - 1) step();

        // single write r0 -> x7
        nv = 2'b01; na[0] = 5'd7; nd[0] = 64'hDEAD_BEEF;
        step();
        nv = 2'b00;
        step();

        // x0 write from r1, pointer returns to 0
        nv = 2'b10; na[1] = 5'd0; nd[1] = 64'h55;
        step();
        nv = 2'b00;
        step();

        // round robin with both valid
        nv = 2'b11; na[0] = 5'd3; nd[0] = 64'd3; na[1] = 5'd4; nd[1] = 64'd4;
        repeat (8) step();
        nv = 2'b00;
        step();

        // reset in the cycle r0 (to x9) would be granted
        nv = 2'b01; na[0] = 5'd9; nd[0] = 64'h9999_0000_9999;
        nrst = 1'b1;
        step();
        nrst = 1'b0; nv = 2'b00;
        repeat (NREG - 1) step();

        // ten cycles of contention, then reset clears the stall count
        nv = 2'b11; na[0] = 5'd10; nd[0] = 64'hA; na[1] = 5'd11; nd[1] = 64'hB;
        repeat (10) step();
        nv = 2'b00;
        step();
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        repeat (NREG - 1) step();

        // randomized traffic with occasional resets
        rand_cycles(500, 4);
        nv = 2'b00;
        repeat (NREG + 2) step();

        @(posedge clock);
        #3;
        chk("exp_q_drained", DW'(exp_q.size()), '0);
        for (int r = 0; r < NREG; r++) chk($sformatf("rf_x%0d", r), rf_dut[r], rf_model[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
